// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// PS2HostTx (ps2_host_tx)
// Host-to-device PS/2 transmitter for the keyboard port.
//
// The PicoBlaze writes a command byte to TX_PORT. The block then runs the
// host side of the PS/2 protocol:
//   - pulls the clock low to inhibit the device;
//   - issues the request-to-send / start bit;
//   - shifts eight data bits (LSB first), odd parity and the stop bit,
//     changing data on each device clock falling edge;
//   - samples the device ACK.
// The response bytes from the keyboard are left to the existing receiver.
//
// Ports:
//   CLK           system clock (100 MHz)
//   RESET         synchronous active-high reset
//   Port_ID       micro port address
//   IN_DATA       micro write data
//   Write_Strobe  micro write qualifier
//   Read_Strobe   micro read qualifier (status is readable without it)
//   OUT_DATA      registered status byte {5'b0, error, ack_ok, busy}
//   PS2_Clock     open-drain clock line (driven 0 or Z only)
//   PS2_Data      open-drain data line (driven 0 or Z only)
//   busy          transmission in progress
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter logic [7:0]  TX_PORT        = 8'h0C,
    parameter logic [7:0]  STATUS_PORT    = 8'h0D,
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Port_ID,
    input  logic [7:0] IN_DATA,
    input  logic       Write_Strobe,
    input  logic       Read_Strobe,
    output logic [7:0] OUT_DATA,
    inout  wire        PS2_Clock,
    inout  wire        PS2_Data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [31:0] inhCnt_q, inhCnt_d;
    logic [31:0] toCnt_q, toCnt_d;
    logic        dataRel_q, dataRel_d;
    logic        ackOk_q, ackOk_d;
    logic        error_q, error_d;
    logic [7:0]  outData_q, outData_d;

    logic [1:0]  clkSync_q;
    logic [1:0]  dataSync_q;
    logic        clkPrev_q;

    logic        clkS;
    logic        dataS;
    logic        fall;
    logic        startReq;
    logic        timeoutHit;
    logic        clkDrive;
    logic        dataDrive;

    // Read_Strobe carries no function here; status is decoded from Port_ID.
    logic        unusedRead;
    assign unusedRead = Read_Strobe;

    assign clkS  = clkSync_q[1];
    assign dataS = dataSync_q[1];
    // A fall needs a synchronized 1 followed by a 0, so the slow rise of a
    // just-released clock line cannot produce a spurious edge.
    assign fall  = clkPrev_q & ~clkS;

    assign startReq   = Write_Strobe && (Port_ID == TX_PORT) && (state_q == IDLE);
    assign timeoutHit = ((state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE))
                        && (toCnt_q == TIMEOUT_CYCLES - 1);

    // State register plus line synchronizers. Synchronizers reset to the
    // idle (pulled-up) level so that no edge is seen after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            bitCnt_q   <= 4'd0;
            inhCnt_q   <= 32'd0;
            toCnt_q    <= 32'd0;
            dataRel_q  <= 1'b1;
            ackOk_q    <= 1'b0;
            error_q    <= 1'b0;
            outData_q  <= 8'h00;
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bitCnt_q   <= bitCnt_d;
            inhCnt_q   <= inhCnt_d;
            toCnt_q    <= toCnt_d;
            dataRel_q  <= dataRel_d;
            ackOk_q    <= ackOk_d;
            error_q    <= error_d;
            outData_q  <= outData_d;
            clkSync_q  <= {clkSync_q[0], PS2_Clock};
            dataSync_q <= {dataSync_q[0], PS2_Data};
            clkPrev_q  <= clkS;
        end
    end

    // Next-state and datapath logic. The timeout override sits after the
    // case so it beats a fall arriving in the same cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bitCnt_d  = bitCnt_q;
        inhCnt_d  = inhCnt_q;
        toCnt_d   = toCnt_q;
        dataRel_d = dataRel_q;
        ackOk_d   = ackOk_q;
        error_d   = error_q;
        outData_d = (Port_ID == STATUS_PORT) ? {5'b0, error_q, ackOk_q, busy} : 8'h00;

        case (state_q)
            IDLE: begin
                dataRel_d = 1'b1;
                if (startReq) begin
                    shift_d  = IN_DATA;
                    parity_d = ~^IN_DATA;
                    ackOk_d  = 1'b0;
                    error_d  = 1'b0;
                    inhCnt_d = 32'd0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inhCnt_q == INHIBIT_CYCLES - 1) begin
                    inhCnt_d = 32'd0;
                    state_d  = REQUEST;
                end else begin
                    inhCnt_d = inhCnt_q + 32'd1;
                end
            end
            REQUEST: begin
                bitCnt_d  = 4'd0;
                toCnt_d   = 32'd0;
                dataRel_d = 1'b0;
                state_d   = SEND;
            end
            SEND: begin
                toCnt_d = toCnt_q + 32'd1;
                if (fall) begin
                    if (bitCnt_q < 4'd8) begin
                        dataRel_d = shift_q[bitCnt_q[2:0]];
                    end else if (bitCnt_q == 4'd8) begin
                        dataRel_d = parity_q;
                    end else begin
                        dataRel_d = 1'b1;
                        state_d   = ACK;
                    end
                    bitCnt_d = bitCnt_q + 4'd1;
                end
            end
            ACK: begin
                toCnt_d   = toCnt_q + 32'd1;
                dataRel_d = 1'b1;
                if (fall) begin
                    if (dataS == 1'b0) begin
                        ackOk_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                toCnt_d = toCnt_q + 32'd1;
                if (clkS && dataS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeoutHit) begin
            state_d   = IDLE;
            error_d   = 1'b1;
            ackOk_d   = 1'b0;
            dataRel_d = 1'b1;
            toCnt_d   = 32'd0;
        end
    end

    // Line drive and status outputs decoded from the registered state.
    always_comb begin
        clkDrive  = (state_q == INHIBIT) || (state_q == REQUEST);
        dataDrive = (state_q == REQUEST) || ((state_q == SEND) && !dataRel_q);
        busy      = (state_q != IDLE);
    end

    assign PS2_Clock = clkDrive  ? 1'b0 : 1'bz;
    assign PS2_Data  = dataDrive ? 1'b0 : 1'bz;
    assign OUT_DATA  = outData_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter for the keyboard port: sends one command byte from the PicoBlaze (for example 0xED set-LEDs, 0xFF reset) to the keyboard over the shared PS2_Clock/PS2_Data lines. It implements the host side of the bidirectional PS/2 protocol: request-to-send, bit shifting on device clock edges, odd parity, stop bit and ACK check. It shares the open-drain lines with the existing keyboard receiver. It decodes its own write and status ports on the micro bus (Port_ID / IN_DATA / Write_Strobe / Read_Strobe).

## Interface
Parameters:
- TX_PORT, 8'h0C: Port_ID whose write starts a transmission.
- STATUS_PORT, 8'h0D: Port_ID that returns status on OUT_DATA.
- INHIBIT_CYCLES, 10000: clock-low inhibit time (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum time from start of the SEND state to ACK (20 ms).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- Port_ID  in  8  micro port address.
- IN_DATA  in  8  micro output data.
- Write_Strobe  in  1  micro write qualifier.
- Read_Strobe  in  1  micro read qualifier (informational; status is readable without it).
- OUT_DATA  out  8  status byte: {5'b0, error, ack_ok, busy}.
- PS2_Clock  inout  1  open-drain. The block drives 0 or Z, never 1.
- PS2_Data  inout  1  open-drain. The block drives 0 or Z, never 1.
- busy  out  1  transmission in progress.

## Operation
- Input conditioning: PS2_Clock and PS2_Data pass through 2-FF synchronizers. `fall` = synchronized clock was 1 last cycle and is 0 now.
- Start condition: Write_Strobe=1, Port_ID==TX_PORT and state IDLE.
  - Latch IN_DATA into the shift register.
  - Compute parity = ~^IN_DATA (odd parity).
  - Clear ack_ok and error, then enter INHIBIT.
  - A write while not IDLE is ignored; the latched byte, flags and state are unchanged.
- States:
  - IDLE: both lines released (Z). busy=0.
  - INHIBIT: drive clock 0 for INHIBIT_CYCLES cycles, then go to REQUEST.
  - REQUEST: drive clock 0 and data 0 for exactly 1 cycle, then go to SEND. This is the start bit.
  - SEND: release clock and keep driving data 0. bit_cnt=0 and the timeout counter start here.
    - On each `fall`: bit_cnt 0–7 puts data bit bit_cnt on the line (LSB first); 8 puts parity; 9 releases data (stop bit).
    - A data bit of 1 means release (Z); 0 means drive 0.
    - bit_cnt increments on every `fall`. When bit_cnt==9 has been handled, go to ACK.
  - ACK: data released. On the next `fall`, sample synchronized data: 0 sets ack_ok=1, 1 sets error=1. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then go to IDLE.
- Timeout: counter runs in SEND, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES: release both lines, set error=1, clear ack_ok, go to IDLE.
- ack_ok and error are sticky until the next accepted write or RESET.
- busy = (state != IDLE).
- The block never interprets response bytes from the keyboard (0xFA, etc.); the existing receiver handles those.

## Timing
- Reset values:
  - state IDLE, both lines Z.
  - busy=0, OUT_DATA=8'h00, ack_ok=0, error=0.
  - shift register 0, bit_cnt 0, counters 0.
- RESET asserted mid-transfer: both lines are released at the next CLK edge and all state is cleared. No partial retry.
- Accepted write to first clock-low drive: 1 cycle (state INHIBIT visible the cycle after the strobe).
- Synchronizer latency: 2 cycles. Data changes on the line 3 cycles after the physical falling edge of PS2_Clock. This is well within the device's low half-period (≥30 µs).
- OUT_DATA is registered:
  - If Port_ID==STATUS_PORT in cycle n, OUT_DATA shows status in cycle n+1.
  - For any other Port_ID, OUT_DATA is 8'h00 in cycle n+1.
- Clock released in SEND while the synchronized clock still reads 0 (line rise time): no `fall` is generated until a 1 has been seen first.
- Timeout and a `fall` in the same cycle: timeout wins.

## Test plan
- Send 0xED with a device model that ACKs. Required response:
  - clock held low for exactly 10000 cycles, then data low.
  - line sequence after the start bit: 1,0,1,1,0,1,1,1.
  - parity 1, stop bit released.
  - status reads 8'h02; busy returns to 0.
- Send 0x00 with a NACK device (data high at the ACK edge). Required: parity bit 1, status 8'h04 (error set, ack_ok clear).
- Device never clocks after the request. Required: at TIMEOUT_CYCLES after SEND entry, lines are Z, status 8'h04, busy=0.
- Write 0xFF to TX_PORT during an active send of 0xF4. Required: the transmitted bits remain 0xF4 and the second write is dropped.
- Assert RESET halfway through the data bits. Required: both lines Z the next cycle, status 8'h00, and a fresh write of 0xED afterwards completes with status 8'h02.
- Write to TX_PORT+1 with Write_Strobe=1 while IDLE. Required: no line activity and busy stays 0.
